// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM.
// A command starts a write or read burst of cmd_len words from cmd_adr.
// Writes stream in with valid/ready handshakes. Reads issue one address
// per cycle and return data one cycle later with no backpressure.
module ram_burst_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [AW-1:0] cmd_adr,
    input  logic [7:0]    cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic          ram_we,
    output logic          ram_start,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] adr_cnt;
    logic [7:0]    cnt;
    logic [AW-1:0] adr_hold;
    logic [DW-1:0] din_hold;
    logic          handshake;
    logic          beat;

    assign handshake = cmd_valid && cmd_ready;
    assign beat      = (state == WRITE) && wr_valid;
    assign rd_data   = ram_dout;

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: bursts end when the remaining count reaches zero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (cmd_len == 8'd0) begin
                        state_next = DONE;
                    end else if (cmd_rw) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                if (beat && (cnt == 8'd1)) begin
                    state_next = DONE;
                end
            end
            READ: begin
                if (cnt == 8'd1) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address counter and remaining count; the address wraps naturally at 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_cnt <= '0;
            cnt     <= 8'd0;
        end else if (handshake) begin
            adr_cnt <= cmd_adr;
            cnt     <= cmd_len;
        end else if (beat || (state == READ)) begin
            adr_cnt <= adr_cnt + AW'(1);
            cnt     <= cnt - 8'd1;
        end
    end

    // Remember the last driven RAM address and data so they hold between bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_hold <= '0;
            din_hold <= '0;
        end else begin
            adr_hold <= ram_adr;
            din_hold <= ram_din;
        end
    end

    // Read data from the RAM is valid one cycle after a read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ram_start && !ram_we;
        end
    end

    // Output decode from the current state.
    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        wr_ready  = 1'b0;
        ram_start = 1'b0;
        ram_we    = 1'b0;
        ram_adr   = adr_hold;
        ram_din   = din_hold;
        done      = (state == DONE);
        case (state)
            WRITE: begin
                wr_ready  = 1'b1;
                ram_start = wr_valid;
                ram_we    = wr_valid;
                ram_adr   = adr_cnt;
                ram_din   = wr_data;
            end
            READ: begin
                ram_start = 1'b1;
                ram_adr   = adr_cnt;
            end
            default: ;
        endcase
    end

endmodule
